// File: rtl/axis_quad_broadcast.sv
// Purpose: one AXI-Stream input fanned out bit-exact to four outputs, each gated by a per-packet enable mask.
// Latency: a beat accepted at edge N is valid on the enabled outputs from cycle N+1. Full rate while all enabled outputs are ready.
// Backpressure: s_axis_tready drops while any output that still owes the held beat is not ready. An output that has taken the beat drops its tvalid.
//
// Ports:
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   s_axis_*               input stream (tdata, tlast, tvalid, tready)
//   m0..m3_axis_*          output streams (tdata, tlast, tvalid, tready)
//   channel_en             requested output mask, sampled on the first beat of each packet
//   active_mask            mask in force for the current packet
//   pkt_count, drop_count  accepted tlast beats, and beats accepted while the mask was zero
module axis_quad_broadcast #(
    parameter int DATA_WIDTH  = 256,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m0_axis_tdata,
    output logic                   m0_axis_tlast,
    output logic                   m0_axis_tvalid,
    input  logic                   m0_axis_tready,
    output logic [DATA_WIDTH-1:0]  m1_axis_tdata,
    output logic                   m1_axis_tlast,
    output logic                   m1_axis_tvalid,
    input  logic                   m1_axis_tready,
    output logic [DATA_WIDTH-1:0]  m2_axis_tdata,
    output logic                   m2_axis_tlast,
    output logic                   m2_axis_tvalid,
    input  logic                   m2_axis_tready,
    output logic [DATA_WIDTH-1:0]  m3_axis_tdata,
    output logic                   m3_axis_tlast,
    output logic                   m3_axis_tvalid,
    input  logic                   m3_axis_tready,
    input  logic [3:0]             channel_en,
    output logic [3:0]             active_mask,
    output logic [COUNT_WIDTH-1:0] pkt_count,
    output logic [COUNT_WIDTH-1:0] drop_count
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic                  hold_last;
    logic [3:0]            pending;
    logic [3:0]            m_rdy;
    logic [3:0]            beat_mask;
    logic                  in_hs;

    assign m_rdy = {m3_axis_tready, m2_axis_tready, m1_axis_tready, m0_axis_tready};

    // Combinational from the m*_tready inputs: a new beat may load in the
    // same cycle that the last owing output takes the current one.
    assign s_axis_tready = ((pending & ~m_rdy) == 4'b0000);
    assign in_hs         = s_axis_tvalid & s_axis_tready;

    // The mask is latched only on a packet's first beat; later beats reuse it.
    assign beat_mask = (state == ST_IDLE) ? channel_en : active_mask;

    assign m0_axis_tdata  = hold_dat;
    assign m1_axis_tdata  = hold_dat;
    assign m2_axis_tdata  = hold_dat;
    assign m3_axis_tdata  = hold_dat;
    assign m0_axis_tlast  = hold_last;
    assign m1_axis_tlast  = hold_last;
    assign m2_axis_tlast  = hold_last;
    assign m3_axis_tlast  = hold_last;
    assign m0_axis_tvalid = pending[0];
    assign m1_axis_tvalid = pending[1];
    assign m2_axis_tvalid = pending[2];
    assign m3_axis_tvalid = pending[3];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            hold_dat    <= '0;
            hold_last   <= 1'b0;
            pending     <= 4'b0000;
            active_mask <= 4'b0000;
            pkt_count   <= '0;
            drop_count  <= '0;
        end else begin
            if (in_hs) begin
                // A load implies every owing output completed this cycle,
                // so overwriting pending loses nothing.
                hold_dat  <= s_axis_tdata;
                hold_last <= s_axis_tlast;
                pending   <= beat_mask;
                if (beat_mask == 4'b0000) begin
                    drop_count <= drop_count + CNT_ONE;
                end
                if (s_axis_tlast) begin
                    pkt_count <= pkt_count + CNT_ONE;
                end
                if (state == ST_IDLE) begin
                    active_mask <= channel_en;
                end
                state <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
            end else begin
                pending <= pending & ~m_rdy;
            end
        end
    end

endmodule

// File: tb/tb_axis_quad_broadcast.sv
module tb_axis_quad_broadcast;

    localparam int DW = 256;
    localparam int CW = 32;

    logic          clock = 1'b0;
    logic          resetn;
    logic [DW-1:0] s_dat;
    logic          s_last;
    logic          s_vld;
    wire           s_rdy;
    wire  [DW-1:0] m_dat [4];
    wire  [3:0]    m_last;
    wire  [3:0]    m_vld;
    logic [3:0]    m_rdy;
    logic [3:0]    channel_en;
    wire  [3:0]    active_mask;
    wire  [CW-1:0] pkt_count;
    wire  [CW-1:0] drop_count;

    always #5 clock = ~clock;

    axis_quad_broadcast #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .s_axis_tdata   (s_dat),
        .s_axis_tlast   (s_last),
        .s_axis_tvalid  (s_vld),
        .s_axis_tready  (s_rdy),
        .m0_axis_tdata  (m_dat[0]),
        .m0_axis_tlast  (m_last[0]),
        .m0_axis_tvalid (m_vld[0]),
        .m0_axis_tready (m_rdy[0]),
        .m1_axis_tdata  (m_dat[1]),
        .m1_axis_tlast  (m_last[1]),
        .m1_axis_tvalid (m_vld[1]),
        .m1_axis_tready (m_rdy[1]),
        .m2_axis_tdata  (m_dat[2]),
        .m2_axis_tlast  (m_last[2]),
        .m2_axis_tvalid (m_vld[2]),
        .m2_axis_tready (m_rdy[2]),
        .m3_axis_tdata  (m_dat[3]),
        .m3_axis_tlast  (m_last[3]),
        .m3_axis_tvalid (m_vld[3]),
        .m3_axis_tready (m_rdy[3]),
        .channel_en     (channel_en),
        .active_mask    (active_mask),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // 16-bit samples all carrying the value b
    function automatic logic [DW-1:0] mk(input logic [7:0] b);
        mk = {16{{8'h00, b}}};
    endfunction

    typedef struct {
        logic       sv;
        logic       sl;
        logic [7:0] d;
        logic [3:0] en;
        logic [3:0] rdy;
        logic       e_srdy;
        logic [3:0] e_mvld;
        logic [7:0] e_d;
        logic       e_l;
        logic [3:0] e_am;
        int         e_pkt;
        int         e_drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sv, input logic sl, input logic [7:0] d, input logic [3:0] en,
                       input logic [3:0] rdy, input logic esr, input logic [3:0] emv, input logic [7:0] ed,
                       input logic el, input logic [3:0] eam, input int ep, input int edr);
        vec_t v;
        v.sv = sv; v.sl = sl; v.d = d; v.en = en; v.rdy = rdy;
        v.e_srdy = esr; v.e_mvld = emv; v.e_d = ed; v.e_l = el;
        v.e_am = eam; v.e_pkt = ep; v.e_drop = edr;
        tbl.push_back(v);
    endtask

    task automatic check_all_data(input string nm, input logic [DW-1:0] ed, input logic el);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s m%0d_tdata", nm, i), m_dat[i], ed);
            chk($sformatf("%s m%0d_tlast", nm, i), {255'd0, m_last[i]}, {255'd0, el});
        end
    endtask

    // Reference model: one queue of owed beats per output; a beat is
    // appended to every output in its packet mask and removed on handshake.
    logic [DW:0] mq [4][$];
    logic [3:0]  am_m;
    bit          in_pkt_m;
    int unsigned pkt_m, drop_m;

    initial begin
        logic       exp_srdy;
        logic [3:0] exp_mvld;
        logic [3:0] mask;
        bit         hold_offer;

        resetn = 1'b0; s_vld = 1'b0; s_last = 1'b0; s_dat = '0;
        m_rdy = 4'b0000; channel_en = 4'b0000;
        #12;
        resetn = 1'b1;
        chk("reset s_tready", {255'd0, s_rdy}, {255'd0, 1'b1});
        chk("reset tvalid", {252'd0, m_vld}, '0);
        check_all_data("reset", '0, 1'b0);
        chk("reset active_mask", {252'd0, active_mask}, '0);
        chk("reset pkt_count", {224'd0, pkt_count}, '0);
        chk("reset drop_count", {224'd0, drop_count}, '0);

        // basic broadcast
        add(1,0,8'h01,4'hF,4'hF, 1,4'h0,8'h00,0,4'h0,0,0);
        add(1,0,8'h02,4'hF,4'hF, 1,4'hF,8'h01,0,4'hF,0,0);
        add(1,0,8'h03,4'hF,4'hF, 1,4'hF,8'h02,0,4'hF,0,0);
        add(1,1,8'h04,4'hF,4'hF, 1,4'hF,8'h03,0,4'hF,0,0);
        add(0,0,8'h00,4'hF,4'hF, 1,4'hF,8'h04,1,4'hF,1,0);
        // partial mask, then a single-beat packet to all
        add(1,0,8'h05,4'h5,4'hF, 1,4'h0,8'h00,0,4'hF,1,0);
        add(1,1,8'h06,4'h5,4'hF, 1,4'h5,8'h05,0,4'h5,1,0);
        add(1,1,8'h07,4'hF,4'hF, 1,4'h5,8'h06,1,4'h5,2,0);
        // skewed backpressure: m2 not ready for 5 cycles
        add(1,0,8'h08,4'hF,4'hB, 0,4'hF,8'h07,1,4'hF,3,0);
        for (int k = 0; k < 4; k++)
            add(1,0,8'h08,4'hF,4'hB, 0,4'h4,8'h07,1,4'hF,3,0);
        add(1,0,8'h08,4'hF,4'hF, 1,4'h4,8'h07,1,4'hF,3,0);
        add(1,1,8'h09,4'hF,4'hF, 1,4'hF,8'h08,0,4'hF,3,0);
        add(0,0,8'h00,4'hF,4'hF, 1,4'hF,8'h09,1,4'hF,4,0);
        // mask change mid-packet
        add(1,0,8'h10,4'hF,4'hF, 1,4'h0,8'h00,0,4'hF,4,0);
        add(1,0,8'h11,4'h1,4'hF, 1,4'hF,8'h10,0,4'hF,4,0);
        add(1,1,8'h12,4'h1,4'hF, 1,4'hF,8'h11,0,4'hF,4,0);
        add(1,1,8'h13,4'h1,4'hF, 1,4'hF,8'h12,1,4'hF,5,0);
        add(0,0,8'h00,4'h1,4'hF, 1,4'h1,8'h13,1,4'h1,6,0);
        // zero mask
        add(1,0,8'h20,4'h0,4'hF, 1,4'h0,8'h00,0,4'h1,6,0);
        add(1,1,8'h21,4'h0,4'hF, 1,4'h0,8'h00,0,4'h0,6,1);
        add(0,0,8'h00,4'h0,4'hF, 1,4'h0,8'h00,0,4'h0,7,2);

        @(posedge clock); #1;
        for (int r = 0; r < tbl.size(); r++) begin
            s_vld = tbl[r].sv; s_last = tbl[r].sl; s_dat = mk(tbl[r].d);
            channel_en = tbl[r].en; m_rdy = tbl[r].rdy;
            @(negedge clock);
            chk($sformatf("row%0d s_tready", r), {255'd0, s_rdy}, {255'd0, tbl[r].e_srdy});
            chk($sformatf("row%0d tvalid", r), {252'd0, m_vld}, {252'd0, tbl[r].e_mvld});
            chk($sformatf("row%0d active_mask", r), {252'd0, active_mask}, {252'd0, tbl[r].e_am});
            chk($sformatf("row%0d pkt_count", r), {224'd0, pkt_count}, {224'd0, 32'(tbl[r].e_pkt)});
            chk($sformatf("row%0d drop_count", r), {224'd0, drop_count}, {224'd0, 32'(tbl[r].e_drop)});
            if (tbl[r].e_mvld != 4'h0)
                check_all_data($sformatf("row%0d", r), mk(tbl[r].e_d), tbl[r].e_l);
            @(posedge clock); #1;
        end

        // async reset while only m3 still owes a beat
        s_vld = 1'b1; s_last = 1'b0; s_dat = mk(8'h30); channel_en = 4'h8; m_rdy = 4'h0;
        @(negedge clock);
        chk("stall load s_tready", {255'd0, s_rdy}, {255'd0, 1'b1});
        @(posedge clock); #1;
        s_vld = 1'b0;
        #1;
        chk("stall pre-reset tvalid", {252'd0, m_vld}, {252'd0, 4'h8});
        chk("stall pre-reset s_tready", {255'd0, s_rdy}, '0);
        resetn = 1'b0;
        #1;
        chk("async reset tvalid", {252'd0, m_vld}, '0);
        chk("async reset pkt_count", {224'd0, pkt_count}, '0);
        chk("async reset drop_count", {224'd0, drop_count}, '0);
        chk("async reset active_mask", {252'd0, active_mask}, '0);
        chk("async reset s_tready", {255'd0, s_rdy}, {255'd0, 1'b1});
        #2;
        resetn = 1'b1;
        @(posedge clock); #1;
        s_vld = 1'b1; s_last = 1'b1; s_dat = mk(8'h31); channel_en = 4'hF; m_rdy = 4'hF;
        @(negedge clock);
        chk("post-reset s_tready", {255'd0, s_rdy}, {255'd0, 1'b1});
        chk("post-reset idle tvalid", {252'd0, m_vld}, '0);
        @(posedge clock); #1;
        s_vld = 1'b0;
        @(negedge clock);
        chk("post-reset tvalid", {252'd0, m_vld}, {252'd0, 4'hF});
        check_all_data("post-reset", mk(8'h31), 1'b1);
        chk("post-reset pkt_count", {224'd0, pkt_count}, {224'd0, 32'd1});
        chk("post-reset active_mask", {252'd0, active_mask}, {252'd0, 4'hF});

        // clean reset, then randomized traffic against the queue model
        @(posedge clock); #1;
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        am_m = 4'h0; in_pkt_m = 1'b0; pkt_m = 0; drop_m = 0;
        hold_offer = 1'b0;
        @(posedge clock); #1;
        for (int c = 0; c < 600; c++) begin
            if (!hold_offer) begin
                s_vld  = ($urandom_range(0, 3) != 0);
                s_last = ($urandom_range(0, 2) == 0);
                s_dat  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            channel_en = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) m_rdy[i] = ($urandom_range(0, 9) < 7);

            exp_srdy = 1'b1;
            for (int i = 0; i < 4; i++) begin
                exp_mvld[i] = (mq[i].size() != 0);
                if (exp_mvld[i] && !m_rdy[i]) exp_srdy = 1'b0;
            end

            @(negedge clock);
            chk($sformatf("rnd%0d s_tready", c), {255'd0, s_rdy}, {255'd0, exp_srdy});
            chk($sformatf("rnd%0d tvalid", c), {252'd0, m_vld}, {252'd0, exp_mvld});
            chk($sformatf("rnd%0d active_mask", c), {252'd0, active_mask}, {252'd0, am_m});
            chk($sformatf("rnd%0d pkt_count", c), {224'd0, pkt_count}, {224'd0, pkt_m});
            chk($sformatf("rnd%0d drop_count", c), {224'd0, drop_count}, {224'd0, drop_m});
            for (int i = 0; i < 4; i++) begin
                if (exp_mvld[i]) begin
                    chk($sformatf("rnd%0d m%0d_tdata", c, i), m_dat[i], mq[i][0][DW-1:0]);
                    chk($sformatf("rnd%0d m%0d_tlast", c, i), {255'd0, m_last[i]}, {255'd0, mq[i][0][DW]});
                end
            end

            @(posedge clock);
            for (int i = 0; i < 4; i++)
                if (mq[i].size() != 0 && m_rdy[i]) void'(mq[i].pop_front());
            if (s_vld && exp_srdy) begin
                if (!in_pkt_m) am_m = channel_en;
                mask = am_m;
                for (int i = 0; i < 4; i++)
                    if (mask[i]) mq[i].push_back({s_last, s_dat});
                if (mask == 4'h0) drop_m++;
                if (s_last) pkt_m++;
                in_pkt_m = !s_last;
            end
            hold_offer = s_vld && !exp_srdy;
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
